// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states, opcodes and
// datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StRWb      = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StImmExec  = 4'd11,
        StImmWb    = 4'd12,
        StTrap     = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_AND   = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_REG      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR     = 2'b01;
    localparam logic [1:0] ALU_B_IMM      = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SHL2 = 2'b11;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating memory-wait counter with a timeout compare; TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WAIT_W-1:0] CntMax = '1;

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = (TIMEOUT != 0) && (cnt_q == WAIT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory handshake timeout and retired count.
// Optional andi support is enabled by defining CTRL_ANDI_EN.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_to_reg_o,
    output logic                ir_write_o,
    output logic                alu_src_a_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic [1:0]          pc_source_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic                instr_done_o,
    output logic [CNT_W-1:0]    instr_count_o,
    output logic                fault_o,
    output logic [3:0]          state_o
);

    localparam logic [OPCODE_W-1:0] OpRtype = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(OP_SW);
`ifdef CTRL_ANDI_EN
    localparam logic [OPCODE_W-1:0] OpAndi  = OPCODE_W'(OP_ANDI);
`endif

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                wait_clear, wait_en, wait_expire;

    function automatic state_e decode_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OpRtype:     return StExecR;
            OpLw, OpSw:  return StMemAddr;
            OpBeq:       return StBranch;
            OpJ:         return StJump;
            OpAddi:      return StImmExec;
`ifdef CTRL_ANDI_EN
            OpAndi:      return StImmExec;
`endif
            default:     return StTrap;
        endcase
    endfunction

    // Counter restarts on every entry to a wait state, including FETCH after MEM_WRITE.
    assign wait_clear = is_wait_state(state_d) && (state_d != state_q);
    assign wait_en    = is_wait_state(state_q) && !mem_ready_i;

    mem_wait_timer #(
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wait_clear),
        .en_i     (wait_en),
        .expire_o (wait_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= '0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     state_d = StFetch;
            StFetch: begin
                if (mem_ready_i)      state_d = StDecode;
                else if (wait_expire) state_d = StTrap;
            end
            StDecode:   state_d = decode_op(opcode_i);
            StMemAddr:  state_d = (op_q == OpLw) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_ready_i)      state_d = StMemWb;
                else if (wait_expire) state_d = StTrap;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (mem_ready_i)      state_d = StFetch;
                else if (wait_expire) state_d = StTrap;
            end
            StExecR:    state_d = StRWb;
            StRWb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StImmExec:  state_d = StImmWb;
            StImmWb:    state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StTrap;
        endcase
    end

    assign op_d    = (state_q == StDecode) ? opcode_i : op_q;
    assign fault_d = fault_q | (state_d == StTrap);
    assign count_d = count_q + CNT_W'(instr_done_o);

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        ir_write_o      = 1'b0;
        alu_src_a_o     = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        pc_source_o     = PC_SRC_ALU;
        alu_src_b_o     = ALU_B_REG;
        alu_op_o        = ALU_OP_ADD;
        instr_done_o    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = ALU_B_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            StDecode:   alu_src_b_o = ALU_B_IMM_SHL2;
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_IMM;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            StMemWrite: begin
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ready_i;
            end
            StExecR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_OP_FUNCT;
            end
            StRWb: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            StBranch: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_OP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PC_SRC_ALUOUT;
                instr_done_o    = 1'b1;
            end
            StJump: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PC_SRC_JUMP;
                instr_done_o = 1'b1;
            end
            StImmExec: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_IMM;
`ifdef CTRL_ANDI_EN
                alu_op_o    = (op_q == OpAndi) ? ALU_OP_AND : ALU_OP_ADD;
`else
                alu_op_o    = ALU_OP_ADD;
`endif
            end
            StImmWb: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_count_o = count_q;
    assign fault_o       = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, R-type, lw wait, sw timeout, addi, beq/j,
// async reset mid-instruction and opcode 12 with or without CTRL_ANDI_EN.
module tb_multicycle_control;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic        ir_write, alu_src_a, reg_write, reg_dst, instr_done, fault;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [15:0] instr_count;
    logic [3:0]  state;
    logic [16:0] ctl;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    multicycle_control dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_to_reg_o    (mem_to_reg),
        .ir_write_o      (ir_write),
        .alu_src_a_o     (alu_src_a),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .pc_source_o     (pc_source),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .instr_done_o    (instr_done),
        .instr_count_o   (instr_count),
        .fault_o         (fault),
        .state_o         (state)
    );

    // Bit order: pcw pcwc iord mr mw m2r irw asa rw rd | pc_source | alu_src_b | alu_op | done
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                  alu_src_a, reg_write, reg_dst, pc_source, alu_src_b, alu_op, instr_done};

    localparam logic [16:0] C_ZERO     = '0;
    localparam logic [16:0] C_FETCH_W  = {10'b0001000000, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] C_FETCH_R  = {10'b1001001000, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] C_DECODE   = {10'b0000000000, 2'b00, 2'b11, 2'b00, 1'b0};
    localparam logic [16:0] C_MEM_ADDR = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] C_MEM_RD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MEM_WB   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_MEM_WR_W = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MEM_WR_R = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_EXEC_R   = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] C_R_WB     = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_BRANCH   = {10'b0100000100, 2'b01, 2'b00, 2'b01, 1'b1};
    localparam logic [16:0] C_JUMP     = {10'b1000000000, 2'b10, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_IMM_ADD  = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] C_IMM_WB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1};
`ifdef CTRL_ANDI_EN
    localparam logic [16:0] C_IMM_AND  = {10'b0000000100, 2'b00, 2'b10, 2'b11, 1'b0};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [16:0] c);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    // Advance one clock, then drive inputs away from the edge and let them settle.
    task automatic step(input logic [5:0] op, input logic rdy);
        @(posedge clk_i);
        #1;
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        opcode    = '0;
        mem_ready = 1'b0;

        repeat (3) begin
            step(6'd0, 1'b0);
            expect_st("reset", 4'd0, C_ZERO);
            chk("reset.fault", 32'(fault), 32'd0);
            chk("reset.count", 32'(instr_count), 32'd0);
        end
        rst_ni = 1'b1;
        #1;
        expect_st("release", 4'd0, C_ZERO);

        // R-type
        step(6'd0, 1'b0);
        expect_st("fetch_wait", 4'd1, C_FETCH_W);
        mem_ready = 1'b1;
        #1;
        expect_st("fetch_rdy", 4'd1, C_FETCH_R);
        step(6'd0, 1'b0);  expect_st("r.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("r.exec", 4'd7, C_EXEC_R);
        step(6'd0, 1'b0);  expect_st("r.wb", 4'd8, C_R_WB);
        chk("r.count_before", 32'(instr_count), 32'd0);
        step(6'd35, 1'b1); expect_st("r.fetch", 4'd1, C_FETCH_R);
        chk("r.count", 32'(instr_count), 32'd1);

        // lw with three wait cycles; opcode changed after DECODE must be ignored
        step(6'd35, 1'b0); expect_st("lw.decode", 4'd2, C_DECODE);
        step(6'd4, 1'b0);  expect_st("lw.addr", 4'd3, C_MEM_ADDR);
        step(6'd4, 1'b0);  expect_st("lw.rd0", 4'd4, C_MEM_RD);
        step(6'd4, 1'b0);  expect_st("lw.rd1", 4'd4, C_MEM_RD);
        step(6'd4, 1'b0);  expect_st("lw.rd2", 4'd4, C_MEM_RD);
        step(6'd4, 1'b1);  expect_st("lw.rd3", 4'd4, C_MEM_RD);
        step(6'd0, 1'b0);  expect_st("lw.wb", 4'd5, C_MEM_WB);
        step(6'd43, 1'b1); expect_st("lw.fetch", 4'd1, C_FETCH_R);
        chk("lw.count", 32'(instr_count), 32'd2);

        // sw with memory never ready: 16 cycles in MEM_WRITE, then TRAP
        step(6'd43, 1'b0); expect_st("sw.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("sw.addr", 4'd3, C_MEM_ADDR);
        for (int i = 0; i < 16; i++) begin
            step(6'd0, 1'b0);
            expect_st("sw.wait", 4'd6, C_MEM_WR_W);
        end
        step(6'd0, 1'b0);  expect_st("sw.trap", 4'd15, C_ZERO);
        chk("sw.fault", 32'(fault), 32'd1);
        step(6'd0, 1'b1);  expect_st("trap.stay", 4'd15, C_ZERO);
        chk("trap.fault_sticky", 32'(fault), 32'd1);
        chk("trap.count", 32'(instr_count), 32'd2);

        // Asynchronous reset clears trap and fault
        rst_ni = 1'b0;
        #1;
        expect_st("rst2", 4'd0, C_ZERO);
        chk("rst2.fault", 32'(fault), 32'd0);
        chk("rst2.count", 32'(instr_count), 32'd0);
        step(6'd0, 1'b0);
        rst_ni = 1'b1;

        // sw completing immediately
        step(6'd43, 1'b1); expect_st("sw2.fetch", 4'd1, C_FETCH_R);
        step(6'd43, 1'b0); expect_st("sw2.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("sw2.addr", 4'd3, C_MEM_ADDR);
        step(6'd0, 1'b1);  expect_st("sw2.write", 4'd6, C_MEM_WR_R);
        step(6'd8, 1'b1);  expect_st("sw2.fetch_next", 4'd1, C_FETCH_R);
        chk("sw2.count", 32'(instr_count), 32'd1);

        // addi
        step(6'd8, 1'b0);  expect_st("addi.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("addi.exec", 4'd11, C_IMM_ADD);
        step(6'd0, 1'b0);  expect_st("addi.wb", 4'd12, C_IMM_WB);
        step(6'd4, 1'b1);  expect_st("addi.fetch", 4'd1, C_FETCH_R);
        chk("addi.count", 32'(instr_count), 32'd2);

        // beq then j back to back, opcode switched during FETCH
        step(6'd4, 1'b0);  expect_st("beq.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("beq.branch", 4'd9, C_BRANCH);
        step(6'd2, 1'b1);  expect_st("j.fetch", 4'd1, C_FETCH_R);
        chk("beq.count", 32'(instr_count), 32'd3);
        step(6'd2, 1'b0);  expect_st("j.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("j.jump", 4'd10, C_JUMP);

        // Reset mid-JUMP clears every output without a clock edge
        rst_ni = 1'b0;
        #1;
        expect_st("rst_jump", 4'd0, C_ZERO);
        chk("rst_jump.count", 32'(instr_count), 32'd0);
        chk("rst_jump.fault", 32'(fault), 32'd0);
        step(6'd0, 1'b0);
        rst_ni = 1'b1;

        // Opcode 12
        step(6'd12, 1'b1); expect_st("op12.fetch", 4'd1, C_FETCH_R);
        step(6'd12, 1'b0); expect_st("op12.decode", 4'd2, C_DECODE);
`ifdef CTRL_ANDI_EN
        step(6'd0, 1'b0);  expect_st("andi.exec", 4'd11, C_IMM_AND);
        step(6'd0, 1'b0);  expect_st("andi.wb", 4'd12, C_IMM_WB);
        step(6'd63, 1'b1); expect_st("andi.fetch", 4'd1, C_FETCH_R);
        chk("andi.count", 32'(instr_count), 32'd1);
        step(6'd63, 1'b0); expect_st("illegal.decode", 4'd2, C_DECODE);
        step(6'd0, 1'b0);  expect_st("illegal.trap", 4'd15, C_ZERO);
        chk("illegal.fault", 32'(fault), 32'd1);
`else
        step(6'd0, 1'b0);  expect_st("op12.trap", 4'd15, C_ZERO);
        chk("op12.fault", 32'(fault), 32'd1);
        chk("op12.count", 32'(instr_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation main control for the MIPS core: a Moore/Mealy FSM sequencing each instruction over 3–5 cycles, replacing the single-cycle opcode decoder.
- Drives datapath mux selects, memory strobes and register-file write. Supports variable-latency memory via a mem_ready handshake with a timeout trap.
- Sits between the instruction register (opcode field) and the shared multi-cycle datapath.

Parameters:
- OPCODE_W, 6, opcode field width.
- WAIT_W, 4, width of the memory-wait counter.
- TIMEOUT, 15, maximum wait cycles before trap; 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- opcode  in  OPCODE_W  Inst[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst  out  1 each  datapath controls.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = and.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- fault  out  1  sticky; set on illegal opcode or memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset asserted: state = IDLE, op_q = 0, wait counter = 0, instr_count = 0, fault = 0. All outputs are 0, including state_o = 0.
- Reset deasserted: IDLE → FETCH on the next edge.
- State encoding and outputs (unlisted outputs are 0):
  - IDLE(0): no outputs asserted.
  - FETCH(1): mem_read=1, alu_src_b=01. ir_write = pc_write = mem_ready (Mealy). Stay in FETCH until mem_ready; then go to DECODE.
  - DECODE(2): alu_src_b=11. Latch op_q <= opcode.
    - opcode 0 → EXEC_R; 35/43 → MEM_ADDR; 4 → BRANCH; 2 → JUMP; 8 → IMM_EXEC.
    - Any other opcode → TRAP.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10. Next: op_q==35 → MEM_READ, else MEM_WRITE.
  - MEM_READ(4): mem_read=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
  - MEM_WB(5): reg_write=1, mem_to_reg=1, instr_done=1. Next: FETCH.
  - MEM_WRITE(6): mem_write=1, i_or_d=1. Wait for mem_ready; instr_done=mem_ready; then FETCH.
  - EXEC_R(7): alu_src_a=1, alu_op=10. Next: R_WB.
  - R_WB(8): reg_dst=1, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH(9): alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
  - JUMP(10): pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
  - IMM_EXEC(11): alu_src_a=1, alu_src_b=10, alu_op=00. Next: IMM_WB.
  - IMM_WB(12): reg_write=1, instr_done=1. Next: FETCH.
  - TRAP(15): fault=1, all strobes 0. Exit only by reset.
- Wait counter (FETCH, MEM_READ, MEM_WRITE only):
  - Cleared on entry to each of these states.
  - Increments each cycle mem_ready=0, saturating at 2^WAIT_W−1.
  - If TIMEOUT≠0 and counter==TIMEOUT with mem_ready=0 → TRAP on the next edge.
  - mem_ready=1 in that same cycle wins; no trap.
- instr_count increments on every cycle with instr_done=1, wrapping 2^CNT_W−1 → 0.
- Opcode changes outside DECODE are ignored; only op_q steers later states.
- Reset asserted mid-instruction aborts immediately; no strobe survives the reset edge.
- mem_write and mem_read are never both 1. reg_write is never 1 in TRAP.

Optional Feature:
- Macro: CTRL_ANDI_EN.
- Defined: opcode 12 (andi) is accepted in DECODE → IMM_EXEC. IMM_EXEC drives alu_op=11 when op_q==12, else 00. IMM_WB is shared.
- Undefined: opcode 12 → TRAP with fault=1.

Decomposition:
- Package mips_ctrl_pkg holds:
  - State encoding constants.
  - Opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_ANDI=12, OP_LW=35, OP_SW=43.
  - ALU_Op, PCSource and ALUSrcB encodings.
- One sub-module: mem_wait_timer, holding the wait counter and timeout compare, with a clear/enable/expire interface.

Test Plan:
- Reset low 3 cycles, release → all outputs 0 during reset; state_o 0 → 1 → FETCH; instr_count=0.
- R-type (opcode 0), mem_ready=1 in FETCH → states 1,2,7,8,1; reg_dst=reg_write=1 in R_WB; instr_count=1.
- lw (35) with mem_ready low 3 cycles in MEM_READ → mem_read/i_or_d held 4 cycles; MEM_WB has mem_to_reg=1. Total latency 8 cycles.
- sw (43) with mem_ready never high, TIMEOUT=15 → TRAP after 16 cycles in MEM_WRITE; fault=1 stays set; mem_write drops to 0.
- Opcode 12 → TRAP with macro undefined; with CTRL_ANDI_EN defined → IMM_EXEC with alu_op=11, then IMM_WB with reg_write=1.
- beq then j back-to-back, opcode changed in FETCH → pc_write_cond/pc_source=01, then pc_write/pc_source=10. Reset asserted mid-JUMP clears all outputs asynchronously.
